ee457_id_ex_reg: RTL
====================

Name: ee457_id_ex_reg

Overview:
ID/EX pipeline register for the five-stage pipelined MIPS datapath. It sits directly downstream of the hazard detection unit and consumes its `stall` output. On a stall or flush it turns the instruction entering EX into a bubble. It also produces `ex_lw` and `ex_wa`, which feed back into the hazard detection unit's load-use check.

Parameters:
- DATA_W, 32, width of register-read data, sign-extended immediate and PC+4.
- CNT_W, 16, width of the saturating bubble and flush statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  load-use stall from the hazard detection unit; inserts a bubble at this edge.
- flush  in  1  taken-branch flush from EX/MEM; inserts a bubble at this edge.
- id_valid  in  1  ID holds a real instruction.
- id_regwrite, id_memtoreg, id_memread, id_memwrite, id_branch, id_alusrc, id_regdst  in  1 each  decoded control bits.
- id_aluop  in  2  ALU operation class.
- id_pc4, id_rs_data, id_rt_data, id_imm  in  DATA_W each  datapath operands.
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- ex_valid  out  1  EX holds a real instruction.
- ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_branch, ex_alusrc, ex_regdst  out  1 each  registered control bits.
- ex_aluop  out  2  registered ALU operation class.
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered operands.
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers (ex_rs and ex_rt also feed the forwarding unit).
- ex_wa  out  5  combinational destination register: ex_regdst ? ex_rd : ex_rt.
- ex_lw  out  1  combinational: ex_valid & ex_memread & (ex_wa != 0).
- bubble_cnt  out  CNT_W  number of stall bubbles inserted.
- flush_cnt  out  CNT_W  number of flush bubbles inserted.

Behaviour:
- Reset: rst=1 clears every registered output and both counters to 0, immediately and independent of clk. A reset asserted mid-pipeline discards the EX instruction.
- Latency: one cycle. Fields present at ID before edge N appear at EX after edge N.
- Normal edge (stall=0, flush=0):
  - All fields are captured.
  - ex_valid <= id_valid.
  - If id_valid=0, the control bits are still captured as presented; decode drives them to 0 for invalid instructions.
- Bubble edge (stall=1 or flush=1):
  - ex_valid, all seven 1-bit controls and ex_aluop are loaded with 0.
  - ex_pc4, data, immediate and specifier fields are loaded from ID, but are don't-care.
  - Therefore ex_lw=0 and ex_regwrite=ex_memwrite=ex_branch=0 after the edge.
- Simultaneous stall=1 and flush=1:
  - A single bubble is inserted.
  - flush_cnt increments; bubble_cnt does not (flush has priority for accounting).
- Counters:
  - bubble_cnt increments on edges with stall=1 and flush=0.
  - flush_cnt increments on edges with flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- This block never holds its contents. A stall keeps IF/ID and PC frozen, but ID/EX always advances (either a bubble or the new instruction), so the stalled load proceeds to MEM.
- $0 rule: a load whose destination is $0 must not raise ex_lw. This prevents a spurious stall on instructions that read $0.
- ex_wa and ex_lw are purely combinational from registered state; there is no path from id_* or stall to them.

Decomposition:
- Shared package ee457_pipe_pkg holds:
  - ALUOP encodings: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10.
  - REG_ZERO=5'd0.
  - CTRL_W=9, the packed control-bundle width, plus a bubble constant of all zeros.
- One sub-module, ee457_sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), is instantiated twice.

Test Plan:
1. Reset: assert rst asynchronously between edges with valid data loaded. All outputs and both counters read 0 before the next edge; ex_lw=0.
2. Normal capture: id_memread=1, id_regwrite=1, id_regdst=0, id_rt=5'd8, id_valid=1, then one edge. ex_wa=8, ex_lw=1, ex_rt=8, and data fields match the inputs.
3. Load-use bubble: an lw to $8 sits in EX and ID holds add $9,$8,$10. With stall=1 for one edge: ex_valid=0, ex_regwrite=0, ex_lw=0, bubble_cnt=1. The next edge with stall=0 captures the add, so ex_regwrite=1 and ex_wa=ex_rd=9.
4. $0 load: id_memread=1, id_rt=0, id_valid=1, then an edge. ex_lw=0 and ex_memread=1.
5. Simultaneous stall=1 and flush=1 on one edge: a single bubble is inserted, flush_cnt=1 and bubble_cnt=0.
6. Saturation with CNT_W=4: hold stall=1 for 20 edges. bubble_cnt stops at 15 and stays 15; deasserting stall leaves it at 15.

Source files
------------

// File: rtl/ee457_pipe_pkg.sv
// Shared encodings and the packed control bundle for the EE457 pipeline registers.
// Pure declarations; no latency or backpressure of its own.
// The bubble constant is the control value that makes an instruction architecturally inert.
package ee457_pipe_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CTRL_W = 9;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic       regdst;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } spec_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Destination register selection shared by any stage that needs a write address.
    function automatic logic [4:0] dest_reg(input logic regdst, input spec_t s);
        return regdst ? s.rd : s.rt;
    endfunction

endpackage

// File: rtl/ee457_sat_counter.sv
// Saturating event counter: counts edges with inc=1, sticks at all-ones.
// Latency: count updates on the edge that samples inc.
// Backpressure: none; inc is ignored once saturated.
module ee457_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = (count == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ee457_id_ex_reg.sv
// ID/EX pipeline register; stall or flush turns the instruction entering EX into a bubble.
// Latency: one cycle, ID fields visible at EX after the capturing edge.
// Backpressure: never holds; stall/flush only zero valid and controls, the stage always advances.
module ee457_id_ex_reg
    import ee457_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic [1:0]        id_aluop,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_alusrc,
    output logic              ex_regdst,
    output logic [1:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_wa,
    output logic              ex_lw,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    spec_t id_spec;
    spec_t ex_spec;
    logic  bubble;
    logic  stall_only;

    assign id_ctrl = '{
        regwrite: id_regwrite,
        memtoreg: id_memtoreg,
        memread:  id_memread,
        memwrite: id_memwrite,
        branch:   id_branch,
        alusrc:   id_alusrc,
        regdst:   id_regdst,
        aluop:    id_aluop
    };

    assign id_spec = '{rs: id_rs, rt: id_rt, rd: id_rd};

    assign bubble     = stall | flush;
    // Flush wins the accounting when both arrive together: one bubble, counted once.
    assign stall_only = stall & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_ctrl;
        end
    end

    // Operands flow through even on a bubble; with valid and controls cleared they are inert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_spec    <= '0;
        end else begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_spec    <= id_spec;
        end
    end

    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_regdst   = ex_ctrl.regdst;
    assign ex_aluop    = ex_ctrl.aluop;
    assign ex_rs       = ex_spec.rs;
    assign ex_rt       = ex_spec.rt;
    assign ex_rd       = ex_spec.rd;

    // A load into $0 writes nothing, so it must not trigger a load-use stall.
    assign ex_wa = dest_reg(ex_ctrl.regdst, ex_spec);
    assign ex_lw = ex_valid & ex_ctrl.memread & (ex_wa != REG_ZERO);

    ee457_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_only),
        .count (bubble_cnt)
    );

    ee457_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
